control_mineria: RTL and testbench

CONTROL_MINERIA -- requirements
Module: control_mineria

---
 rtl/control_mineria.sv | 162 ++++++++++++++++
 tb/tb_control_mineria.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_mineria.sv
`default_nettype none
// ============================================================================
//  Module      : control_mineria
//  Description : Nonce-search controller for a hash core. It launches one
//                hash per nonce, compares the two upper hash bytes against
//                a latched difficulty target, and stops on a match, on
//                nonce-space exhaustion, on a core timeout or on abort.
//                Optional attempt counter enabled by the macro
//                CONTROL_MINERIA_INTENTOS_EN (default build: intentos = 0).
//  Revision    : 1.0 - initial release
// ============================================================================
module control_mineria #(
    parameter int NONCE_W = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inicio,
    input  logic               parar,
    input  logic [NONCE_W-1:0] nonce_inicial,
    input  logic [7:0]         target,
    output logic               hash_inicio,
    output logic [NONCE_W-1:0] nonce,
    input  logic [23:0]        hash,
    input  logic               hash_valido,
    output logic               ocupado,
    output logic               terminado,
    output logic               agotado,
    output logic               error_timeout,
    output logic [NONCE_W-1:0] nonce_encontrado,
    output logic [23:0]        hash_encontrado,
    output logic [31:0]        intentos
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EMITIR  = 3'd1,
        ESPERAR = 3'd2,
        HECHO   = 3'd3,
        AGOTADO = 3'd4,
        ERROR   = 3'd5
    } estado_t;

    estado_t              estado_q, estado_d;
    logic [NONCE_W-1:0]   nonce_q, nonce_d;
    logic [7:0]           target_q, target_d;
    logic [TW-1:0]        espera_q, espera_d;
    logic [NONCE_W-1:0]   nenc_q, nenc_d;
    logic [23:0]          henc_q, henc_d;

    logic w_reposo;
    logic w_acepta;
    logic w_match;

    // A new search can only start from a quiescent state.
    assign w_reposo = (estado_q == IDLE) || (estado_q == HECHO) ||
                      (estado_q == AGOTADO) || (estado_q == ERROR);
    assign w_acepta = w_reposo && inicio;
    assign w_match  = (hash[23:16] < target_q) && (hash[15:8] < target_q);

    // State and datapath registers; reset dominates every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= IDLE;
            nonce_q  <= '0;
            target_q <= '0;
            espera_q <= '0;
            nenc_q   <= '0;
            henc_q   <= '0;
        end else begin
            estado_q <= estado_d;
            nonce_q  <= nonce_d;
            target_q <= target_d;
            espera_q <= espera_d;
            nenc_q   <= nenc_d;
            henc_q   <= henc_d;
        end
    end

    // Next-state logic: abort beats a result or timeout in the same cycle.
    always_comb begin
        estado_d = estado_q;
        nonce_d  = nonce_q;
        target_d = target_q;
        espera_d = espera_q;
        nenc_d   = nenc_q;
        henc_d   = henc_q;
        case (estado_q)
            IDLE, HECHO, AGOTADO, ERROR: begin
                if (inicio) begin
                    estado_d = EMITIR;
                    nonce_d  = nonce_inicial;
                    target_d = target;
                    nenc_d   = '0;
                    henc_d   = '0;
                end
            end
            EMITIR: begin
                espera_d = '0;
                estado_d = parar ? IDLE : ESPERAR;
            end
            ESPERAR: begin
                if (parar) begin
                    estado_d = IDLE;
                end else if (hash_valido) begin
                    if (w_match) begin
                        estado_d = HECHO;
                        nenc_d   = nonce_q;
                        henc_d   = hash;
                    end else if (nonce_q == '1) begin
                        // Last nonce tried: stop rather than wrap to zero.
                        estado_d = AGOTADO;
                    end else begin
                        estado_d = EMITIR;
                        nonce_d  = nonce_q + 1'b1;
                    end
                end else if (espera_q == TW'(TIMEOUT - 1)) begin
                    estado_d = ERROR;
                end else begin
                    espera_d = espera_q + 1'b1;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    // Status outputs decode directly from the state, so the sticky flags are
    // mutually exclusive and cleared by the transition back to EMITIR.
    assign hash_inicio      = (estado_q == EMITIR);
    assign ocupado          = (estado_q == EMITIR) || (estado_q == ESPERAR);
    assign terminado        = (estado_q == HECHO);
    assign agotado          = (estado_q == AGOTADO);
    assign error_timeout    = (estado_q == ERROR);
    assign nonce            = nonce_q;
    assign nonce_encontrado = nenc_q;
    assign hash_encontrado  = henc_q;

`ifdef CONTROL_MINERIA_INTENTOS_EN
    logic [31:0] intentos_q;

    // Saturating count of launch strobes, restarted by each accepted search.
    always_ff @(posedge clk) begin
        if (reset) begin
            intentos_q <= '0;
        end else if (w_acepta) begin
            intentos_q <= '0;
        end else if (hash_inicio && (intentos_q != '1)) begin
            intentos_q <= intentos_q + 1'b1;
        end
    end

    assign intentos = intentos_q;
`else
    logic w_acepta_libre;
    assign w_acepta_libre = w_acepta;
    assign intentos       = {31'd0, w_acepta_libre & 1'b0};
`endif

endmodule
`default_nettype wire

// File: tb/tb_control_mineria.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_mineria
//  Description : Self-checking bench for control_mineria with a behavioural
//                search model, an emulated hash core and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_mineria;

    localparam int NW = 32;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          inicio = 1'b0;
    logic          parar = 1'b0;
    logic [NW-1:0] nonce_inicial = '0;
    logic [7:0]    target = '0;
    logic          hash_inicio;
    logic [NW-1:0] nonce;
    logic [23:0]   hash = '0;
    logic          hash_valido = 1'b0;
    logic          ocupado;
    logic          terminado;
    logic          agotado;
    logic          error_timeout;
    logic [NW-1:0] nonce_encontrado;
    logic [23:0]   hash_encontrado;
    logic [31:0]   intentos;

    always #5 clk = ~clk;

    control_mineria #(.NONCE_W(NW), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .inicio           (inicio),
        .parar            (parar),
        .nonce_inicial    (nonce_inicial),
        .target           (target),
        .hash_inicio      (hash_inicio),
        .nonce            (nonce),
        .hash             (hash),
        .hash_valido      (hash_valido),
        .ocupado          (ocupado),
        .terminado        (terminado),
        .agotado          (agotado),
        .error_timeout    (error_timeout),
        .nonce_encontrado (nonce_encontrado),
        .hash_encontrado  (hash_encontrado),
        .intentos         (intentos)
    );

    // ------------------------------------------------------------------
    // Behavioural model: a search is either running (busy) or finished
    // with an outcome; while running it is either launching or waiting.
    // outcome: 0 none, 1 found, 2 exhausted, 3 timeout
    // ------------------------------------------------------------------
    bit          m_busy = 0;
    bit          m_launch = 0;
    int          m_outcome = 0;
    int          m_wait = 0;
    logic [NW-1:0] m_nonce = '0;
    logic [7:0]  m_tgt = '0;
    logic [NW-1:0] m_fn = '0;
    logic [23:0] m_fh = '0;
    logic [31:0] m_tries = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_launch = 0; m_outcome = 0; m_wait = 0;
            m_nonce = '0; m_tgt = '0; m_fn = '0; m_fh = '0; m_tries = '0;
        end else begin
            if (m_busy && m_launch && m_tries != 32'hFFFF_FFFF)
                m_tries = m_tries + 1;
            if (!m_busy) begin
                if (inicio) begin
                    m_busy = 1; m_launch = 1; m_outcome = 0;
                    m_nonce = nonce_inicial; m_tgt = target;
                    m_fn = '0; m_fh = '0; m_tries = '0;
                end
            end else if (parar) begin
                m_busy = 0; m_launch = 0;
            end else if (m_launch) begin
                m_launch = 0; m_wait = 0;
            end else if (hash_valido) begin
                if ((hash[23:16] < m_tgt) && (hash[15:8] < m_tgt)) begin
                    m_busy = 0; m_outcome = 1; m_fn = m_nonce; m_fh = hash;
                end else if (m_nonce == {NW{1'b1}}) begin
                    m_busy = 0; m_outcome = 2;
                end else begin
                    m_nonce = m_nonce + 1; m_launch = 1;
                end
            end else begin
                m_wait = m_wait + 1;
                if (m_wait >= TO) begin
                    m_busy = 0; m_outcome = 3;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking and stimulus (single process)
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    // Emulated hash core: valid two cycles after the launch strobe.
    bit          r_on = 1;
    int          r_cnt = -1;
    logic [23:0] r_hash = '0;
    int          mode = 0;

    function automatic logic [23:0] hash_fn(input int md, input logic [NW-1:0] n);
        case (md)
            1: return (n == 7) ? 24'h3F2000 : 24'hFFFFFF;
            2: return 24'h000000;
            3: return (n == 7) ? 24'h3F2000 : ((n == 6) ? 24'h505000 : 24'hFFFFFF);
            default: return 24'hFFFFFF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        logic [31:0] exp_tries;
        @(negedge clk);
`ifdef CONTROL_MINERIA_INTENTOS_EN
        exp_tries = m_tries;
`else
        exp_tries = 32'd0;
`endif
        chk("hash_inicio", 64'(hash_inicio), 64'(m_busy && m_launch));
        chk("ocupado", 64'(ocupado), 64'(m_busy));
        chk("terminado", 64'(terminado), 64'(!m_busy && m_outcome == 1));
        chk("agotado", 64'(agotado), 64'(!m_busy && m_outcome == 2));
        chk("error_timeout", 64'(error_timeout), 64'(!m_busy && m_outcome == 3));
        chk("nonce", 64'(nonce), 64'(m_nonce));
        chk("nonce_encontrado", 64'(nonce_encontrado), 64'(m_fn));
        chk("hash_encontrado", 64'(hash_encontrado), 64'(m_fh));
        chk("intentos", 64'(intentos), 64'(exp_tries));
        inicio = 1'b0;
        parar  = 1'b0;
        hash_valido = 1'b0;
        if (r_cnt == 0) begin
            hash_valido = 1'b1;
            hash = r_hash;
            r_cnt = -1;
        end else if (r_cnt > 0) begin
            r_cnt--;
        end
        if (hash_inicio && r_on) begin
            r_hash = hash_fn(mode, nonce);
            r_cnt = 1;
        end
    endtask

    initial begin
        int n;
        int exp_int;
        bit seen;

        repeat (3) tick();
        chk("reset_ocupado", 64'(ocupado), 64'd0);
        chk("reset_nonce", 64'(nonce), 64'd0);
        chk("reset_intentos", 64'(intentos), 64'd0);
        reset = 1'b0;
        tick();

        // Find a match on the third nonce.
        mode = 1; nonce_inicial = 32'd5; target = 8'h40; inicio = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!terminado && n < 60);
        chk("t1_terminado", 64'(terminado), 64'd1);
        chk("t1_nonce_enc", 64'(nonce_encontrado), 64'd7);
        chk("t1_hash_enc", 64'(hash_encontrado), 64'h3F2000);
`ifdef CONTROL_MINERIA_INTENTOS_EN
        exp_int = 3;
`else
        exp_int = 0;
`endif
        chk("t1_intentos", 64'(intentos), 64'(exp_int));
        repeat (2) tick();

        // Exhaust the nonce space from the next-to-last value.
        mode = 0; nonce_inicial = 32'hFFFF_FFFE; inicio = 1'b1;
        n = 0; exp_int = 0;
        do begin tick(); n++; if (hash_inicio) exp_int++; end while (!agotado && n < 60);
        chk("t2_strobes", 64'(exp_int), 64'd2);
        chk("t2_agotado", 64'(agotado), 64'd1);
        chk("t2_nonce", 64'(nonce), 64'hFFFF_FFFF);
        chk("t2_terminado", 64'(terminado), 64'd0);
        repeat (2) tick();

        // Silent hash core: timeout after exactly TO waiting cycles.
        r_on = 0; nonce_inicial = 32'd10; inicio = 1'b1;
        n = 0; exp_int = 0;
        do begin
            tick(); n++;
            if (ocupado && !hash_inicio) exp_int++;
        end while (!error_timeout && n < 300);
        chk("t3_wait_cycles", 64'(exp_int), 64'd64);
        chk("t3_error", 64'(error_timeout), 64'd1);
        chk("t3_ocupado", 64'(ocupado), 64'd0);
        r_on = 1;
        repeat (2) tick();

        // Abort in the same cycle as a matching result.
        mode = 2; nonce_inicial = 32'd3; inicio = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!hash_valido && n < 20);
        chk("t4_valid_seen", 64'(hash_valido), 64'd1);
        parar = 1'b1;
        tick(); tick();
        chk("t4_terminado", 64'(terminado), 64'd0);
        chk("t4_ocupado", 64'(ocupado), 64'd0);

        // Reset while waiting, then restart from nonce 0.
        mode = 0; nonce_inicial = 32'd20; inicio = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!(ocupado && !hash_inicio) && n < 20);
        reset = 1'b1;
        tick();
        r_cnt = -1;
        chk("t5_ocupado", 64'(ocupado), 64'd0);
        chk("t5_nonce", 64'(nonce), 64'd0);
        chk("t5_flags", 64'({terminado, agotado, error_timeout, hash_inicio}), 64'd0);
        chk("t5_found", 64'({nonce_encontrado, hash_encontrado}), 64'd0);
        chk("t5_intentos", 64'(intentos), 64'd0);
        reset = 1'b0;
        tick();
        nonce_inicial = 32'd0; inicio = 1'b1;
        tick();
        chk("t5_launch", 64'(hash_inicio), 64'd1);
        chk("t5_launch_nonce", 64'(nonce), 64'd0);
        parar = 1'b1;
        repeat (3) tick();

        // inicio during a search must not reload nonce or target.
        mode = 3; nonce_inicial = 32'd6; target = 8'h40; inicio = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!(ocupado && !hash_inicio) && n < 20);
        nonce_inicial = 32'd100; target = 8'hFF; inicio = 1'b1;
        tick();
        chk("t6_nonce_held", 64'(nonce), 64'd6);
        n = 0; seen = 0;
        do begin tick(); n++; end while (!terminado && n < 60);
        chk("t6_terminado", 64'(terminado), 64'd1);
        chk("t6_nonce_enc", 64'(nonce_encontrado), 64'd7);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
